clock_enable_bank: RTL and testbench

Parametrised multi-channel clock-enable generator, the successor to the fixed two-output `clock` divider (25 MHz video, PPU) in the NES project. It derives CHANNELS independent enable strobes and square waves from the single system clock `clk`. Each channel runs either as an integer divider or as a fractional NCO, for rates such as the 5.3693 MHz PPU dot clock. Channels are reprogrammed at run time with glitch-free, period-aligned updates and a global phase resync.

---
 rtl/clock_enable_bank_if.sv | 25 ++
 rtl/clock_enable_bank.sv | 157 +++++++++++++++
 tb/tb_clock_enable_bank.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_enable_bank_if.sv
// Configuration and output bundle for clock_enable_bank.
// The master drives configuration and samples the strobes; the slave is the bank.
interface clock_enable_bank_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16
);
  logic                cfg_wr;
  logic [3:0]          cfg_ch;
  logic                cfg_mode;
  logic [WIDTH-1:0]    cfg_val;
  logic                resync;
  logic [CHANNELS-1:0] ce;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] pending;

  modport master (
    output cfg_wr, cfg_ch, cfg_mode, cfg_val, resync,
    input  ce, clk_out, pending
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_mode, cfg_val, resync,
    output ce, clk_out, pending
  );
endinterface

// File: rtl/clock_enable_bank.sv
// Multi-channel clock-enable generator: each channel is an integer divider or a fractional
// NCO, reprogrammed through a shadow register that is applied on a period boundary.
module clock_enable_bank #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  clock_enable_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] v);
    return (v == ZERO) ? ONE : v;
  endfunction

  // ceil(e/2), one bit wider so the largest divisor cannot overflow.
  function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] e);
    logic [WIDTH:0] s;
    s = {1'b0, e} + {{WIDTH{1'b0}}, 1'b1};
    return s >> 1;
  endfunction

  logic [CHANNELS-1:0] ce_vec;
  logic [CHANNELS-1:0] clk_out_vec;
  logic [CHANNELS-1:0] pend_vec;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             act_mode_q, act_mode_d;
    logic [WIDTH-1:0] act_val_q, act_val_d;
    logic             sh_mode_q, sh_mode_d;
    logic [WIDTH-1:0] sh_val_q, sh_val_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             run_q, run_d;
    logic             ce_q, ce_d;
    logic             clk_out_q, clk_out_d;
    logic             wr_hit;
    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] div_e;
    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH:0]   sum;

    assign wr_hit  = bus.cfg_wr && (bus.cfg_ch == 4'(i));
    assign div_e   = eff_div(act_val_q);
    assign wrap    = (cnt_q >= (div_e - ONE));
    assign cnt_inc = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    assign sum     = {1'b0, acc_q} + {1'b0, act_val_q};

    // Next-state: counting, apply of the shadow, then capture of a new write.
    always_comb begin
      act_mode_d = act_mode_q;
      act_val_d  = act_val_q;
      sh_mode_d  = sh_mode_q;
      sh_val_d   = sh_val_q;
      pend_d     = pend_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      carry_d    = carry_q;
      run_d      = run_q;
      ce_d       = 1'b0;
      clk_out_d  = 1'b0;
      apply      = 1'b0;

      if (bus.resync) begin
        cnt_d   = ZERO;
        acc_d   = ZERO;
        carry_d = 1'b0;
        run_d   = 1'b0;
        apply   = pend_q;
      end else if (!act_mode_q) begin
        // run_q keeps clk_out low until the first full period after a restart.
        ce_d      = wrap;
        cnt_d     = wrap ? ZERO : cnt_inc[WIDTH-1:0];
        run_d     = run_q | wrap;
        clk_out_d = wrap | (run_q & (cnt_inc < high_len(div_e)));
        apply     = pend_q & wrap;
      end else begin
        ce_d      = carry_q;
        clk_out_d = acc_q[WIDTH-1];
        acc_d     = sum[WIDTH-1:0];
        carry_d   = sum[WIDTH];
        apply     = pend_q;
      end

      if (apply) begin
        act_mode_d = sh_mode_q;
        act_val_d  = sh_val_q;
        pend_d     = 1'b0;
        if (sh_mode_q != act_mode_q) begin
          cnt_d   = ZERO;
          acc_d   = ZERO;
          carry_d = 1'b0;
          run_d   = 1'b0;
        end else begin
          run_d = run_d;
        end
      end else begin
        pend_d = pend_d;
      end

      // A write on the apply edge lands in the shadow after the old shadow moved out.
      if (wr_hit) begin
        sh_mode_d = bus.cfg_mode;
        sh_val_d  = bus.cfg_val;
        pend_d    = 1'b1;
      end else begin
        sh_mode_d = sh_mode_d;
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act_mode_q <= 1'b0;
        act_val_q  <= RST_VAL;
        sh_mode_q  <= 1'b0;
        sh_val_q   <= RST_VAL;
        pend_q     <= 1'b0;
        cnt_q      <= ZERO;
        acc_q      <= ZERO;
        carry_q    <= 1'b0;
        run_q      <= 1'b0;
        ce_q       <= 1'b0;
        clk_out_q  <= 1'b0;
      end else begin
        act_mode_q <= act_mode_d;
        act_val_q  <= act_val_d;
        sh_mode_q  <= sh_mode_d;
        sh_val_q   <= sh_val_d;
        pend_q     <= pend_d;
        cnt_q      <= cnt_d;
        acc_q      <= acc_d;
        carry_q    <= carry_d;
        run_q      <= run_d;
        ce_q       <= ce_d;
        clk_out_q  <= clk_out_d;
      end
    end

    assign ce_vec[i]      = ce_q;
    assign clk_out_vec[i] = clk_out_q;
    assign pend_vec[i]    = pend_q;
  end

  assign bus.ce      = ce_vec;
  assign bus.clk_out = clk_out_vec;
  assign bus.pending = pend_vec;

endmodule

// File: tb/tb_clock_enable_bank.sv
// Scoreboard bench for clock_enable_bank: a period-level reference model predicts
// {ce, clk_out, pending} after every edge; a negedge monitor compares the DUT against it.
module tb_clock_enable_bank;
  localparam int CH   = 2;
  localparam int W    = 16;
  localparam int MODV = 1 << W;

  logic clk;
  logic rst_n;

  clock_enable_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  clock_enable_bank #(.CHANNELS(CH), .WIDTH(W), .RESET_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [3*CH-1:0] exp_q[$];

  // Reference model: per channel, active/shadow config and period position.
  int m_mode[CH], m_val[CH], s_mode[CH], s_val[CH], m_pend[CH];
  int m_tin[CH], m_since[CH], m_started[CH];
  int m_acc[CH], m_carry[CH], m_ce[CH], m_clk[CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_val[c] = 4; s_mode[c] = 0; s_val[c] = 4; m_pend[c] = 0;
      m_tin[c] = 0; m_since[c] = 0; m_started[c] = 0;
      m_acc[c] = 0; m_carry[c] = 0; m_ce[c] = 0; m_clk[c] = 0;
    end
  endfunction

  function automatic void model_step(input bit wr, input int ch, input bit md, input int v, input bit rs);
    for (int c = 0; c < CH; c++) begin
      bit ap;
      int e;
      ap = 1'b0;
      if (rs) begin
        m_tin[c] = 0; m_since[c] = 0; m_started[c] = 0;
        m_acc[c] = 0; m_carry[c] = 0; m_ce[c] = 0; m_clk[c] = 0;
        ap = (m_pend[c] != 0);
      end else if (m_mode[c] == 0) begin
        e = (m_val[c] == 0) ? 1 : m_val[c];
        m_tin[c]++;
        if (m_tin[c] >= e) begin
          m_ce[c] = 1; m_tin[c] = 0; m_since[c] = 0; m_started[c] = 1;
          ap = (m_pend[c] != 0);
        end else begin
          m_ce[c] = 0; m_since[c]++;
        end
        m_clk[c] = (m_started[c] != 0 && m_since[c] < (e + 1) / 2) ? 1 : 0;
      end else begin
        m_ce[c]  = m_carry[c];
        m_clk[c] = (m_acc[c] >= MODV / 2) ? 1 : 0;
        m_acc[c] = m_acc[c] + m_val[c];
        m_carry[c] = (m_acc[c] >= MODV) ? 1 : 0;
        m_acc[c] = m_acc[c] % MODV;
        ap = (m_pend[c] != 0);
      end
      if (ap) begin
        if (s_mode[c] != m_mode[c]) begin
          m_tin[c] = 0; m_since[c] = 0; m_started[c] = 0; m_acc[c] = 0; m_carry[c] = 0;
        end
        m_mode[c] = s_mode[c]; m_val[c] = s_val[c]; m_pend[c] = 0;
      end
      if (wr && ch == c) begin
        s_mode[c] = md; s_val[c] = v % MODV; m_pend[c] = 1;
      end
    end
  endfunction

  function automatic logic [3*CH-1:0] model_out();
    logic [CH-1:0] a, b, p;
    for (int c = 0; c < CH; c++) begin
      a[c] = (m_ce[c] != 0);
      b[c] = (m_clk[c] != 0);
      p[c] = (m_pend[c] != 0);
    end
    return {a, b, p};
  endfunction

  // One clock with the given inputs; the model sees exactly what the DUT samples.
  task automatic tick(input bit wr, input int ch, input bit md, input int v, input bit rs);
    bus.cfg_wr   = wr;
    bus.cfg_ch   = 4'(ch);
    bus.cfg_mode = md;
    bus.cfg_val  = 16'(v);
    bus.resync   = rs;
    @(posedge clk);
    cyc++;
    model_step(wr, ch, md, v, rs);
    exp_q.push_back(model_out());
    #1;
    bus.cfg_wr = 1'b0;
    bus.resync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: compare each predicted output word away from the active edge.
  always @(negedge clk) begin
    logic [3*CH-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs{ce,clk_out,pending}", 32'({bus.ce, bus.clk_out, bus.pending}), 32'(e));
    end
  end

  initial begin
    bit r_wr, r_md, r_rs;
    int r_ch, r_v, ce_cnt, lo;

    rst_n = 1'b1;
    bus.cfg_wr = 1'b0; bus.cfg_ch = 4'd0; bus.cfg_mode = 1'b0;
    bus.cfg_val = 16'd0; bus.resync = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.ce, bus.clk_out, bus.pending}), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Reset defaults, then ch1 D=5 written mid-period.
    idle(17);
    tick(1'b1, 1, 1'b0, 5, 1'b0);
    idle(30);

    // ch0 to NCO with INC=16384, then INC=3519 rate measurement.
    tick(1'b1, 0, 1'b1, 16384, 1'b0);
    idle(24);
    tick(1'b1, 0, 1'b1, 3519, 1'b0);
    idle(1);
    ce_cnt = 0;
    for (int k = 0; k < 20000; k++) begin
      tick(1'b0, 0, 1'b0, 0, 1'b0);
      if (bus.ce[0]) ce_cnt++;
    end
    lo = (20000 * 3519) / MODV;
    check("nco_rate_ce_count", 32'(ce_cnt), 32'((ce_cnt >= lo - 1 && ce_cnt <= lo + 1) ? ce_cnt : lo));

    // Edge cases: D=0, D=1, INC=0, write to a nonexistent channel.
    tick(1'b1, 1, 1'b0, 0, 1'b0);
    tick(1'b1, 0, 1'b0, 1, 1'b0);
    idle(20);
    tick(1'b1, 0, 1'b1, 0, 1'b0);
    idle(20);
    tick(1'b1, 15, 1'b1, 777, 1'b0);
    idle(10);

    // Resync with a coincident write to ch0.
    tick(1'b1, 0, 1'b0, 3, 1'b0);
    tick(1'b1, 1, 1'b0, 6, 1'b0);
    idle(17);
    tick(1'b1, 0, 1'b0, 7, 1'b1);
    idle(30);

    // Random traffic including invalid channels and resyncs.
    for (int k = 0; k < 3000; k++) begin
      r_wr = ($urandom_range(0, 11) == 0);
      r_ch = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 1));
      r_md = 1'($urandom_range(0, 1));
      r_v  = r_md ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9));
      r_rs = ($urandom_range(0, 79) == 0);
      tick(r_wr, r_ch, r_md, r_v, r_rs);
    end

    // Asynchronous reset between edges with a write still pending.
    tick(1'b1, 1, 1'b0, 9, 1'b0);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_outputs", 32'({bus.ce, bus.clk_out, bus.pending}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    idle(14);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
